fir_transpose_param: RTL and testbench

Parametrised successor to the fixed 12-bit transposed-form FIR. Generic data, coefficient and tap-count widths, with a valid-qualified sample stream and double-buffered coefficients so a new filter loads and swaps in atomically without stalling the stream. Adds round/shift/saturate output scaling, flush, and registered coefficient read-back. Sits between the sample source (ADC front end / test vectors) and downstream DSP.

---
 rtl/fir_pkg.sv | 40 ++++
 rtl/fir_transpose_param_if.sv | 32 +++
 rtl/fir_coef_bank.sv | 66 ++++++
 rtl/fir_transpose_param.sv | 80 ++++++++
 tb/tb_fir_transpose_param.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared sizing and output-scaling helpers for the parametrised transposed FIR.
package fir_pkg;

   // Widest accumulator the scaling helper handles; ACC_W must not exceed it.
   localparam int MAX_ACC_W = 64;

   // Accumulator width that holds a full N-tap sum of DATA_W x COEF_W products.
   function automatic int acc_width(input int data_w, input int coef_w, input int n_taps);
      return data_w + coef_w + $clog2(n_taps);
   endfunction

   // True when a coefficient address names a real tap.
   function automatic logic addr_in_range(input int addr, input int n_taps);
      return (addr < n_taps);
   endfunction

   // Round half up by 2**(shift-1), arithmetic shift right, then clamp to data_w signed.
   function automatic logic signed [MAX_ACC_W-1:0] sat_round(
      input logic signed [MAX_ACC_W-1:0] acc,
      input int                          shift,
      input int                          data_w
   );
      logic signed [MAX_ACC_W-1:0] r;
      logic signed [MAX_ACC_W-1:0] max_v;
      logic signed [MAX_ACC_W-1:0] min_v;
      r = acc;
      if (shift > 0) begin
         r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
      end
      max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (data_w - 1));
      if (r > max_v) begin
         r = max_v;
      end else if (r < min_v) begin
         r = min_v;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_transpose_param_if.sv
// Sample stream and coefficient-port bundle for fir_transpose_param.
interface fir_transpose_param_if #(
   parameter int DATA_W = 12,
   parameter int COEF_W = 12,
   parameter int ADDR_W = 8
);
   logic signed [DATA_W-1:0] Din;
   logic                     din_valid;
   logic                     flush;
   logic signed [DATA_W-1:0] Dout;
   logic                     dout_valid;
   logic                     coef_wr_en;
   logic [ADDR_W-1:0]        coef_wr_addr;
   logic signed [COEF_W-1:0] coef_wr_data;
   logic                     coef_swap;
   logic [ADDR_W-1:0]        coef_rd_addr;
   logic signed [COEF_W-1:0] coef_rd_data;

   // Sample source / coefficient loader side.
   modport master (
      output Din, din_valid, flush,
      output coef_wr_en, coef_wr_addr, coef_wr_data, coef_swap, coef_rd_addr,
      input  Dout, dout_valid, coef_rd_data
   );

   // Filter side.
   modport slave (
      input  Din, din_valid, flush,
      input  coef_wr_en, coef_wr_addr, coef_wr_data, coef_swap, coef_rd_addr,
      output Dout, dout_valid, coef_rd_data
   );
endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes fill the shadow bank, swap flips
// which bank feeds the datapath, read-back is registered from the active bank.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int COEF_W = 12,
   parameter int N_TAPS = 16,
   parameter int ADDR_W = 8
) (
   input  logic                     Clk,
   input  logic                     Hlt_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [COEF_W-1:0] wr_data,
   input  logic                     swap,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic signed [COEF_W-1:0] rd_data,
   output logic signed [COEF_W-1:0] coef [N_TAPS]
);

   localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

   logic signed [COEF_W-1:0] bank [2][N_TAPS];
   logic                     bank_sel;
   logic [IDX_W-1:0]         wr_idx;
   logic [IDX_W-1:0]         rd_idx;
   logic                     wr_ok;
   logic                     rd_ok;

   assign wr_idx = wr_addr[IDX_W-1:0];
   assign rd_idx = rd_addr[IDX_W-1:0];
   assign wr_ok  = addr_in_range(int'(wr_addr), N_TAPS);
   assign rd_ok  = addr_in_range(int'(rd_addr), N_TAPS);

   // Active bank drives the datapath; a swap takes effect only after the edge.
   always_comb begin
      for (int k = 0; k < N_TAPS; k++) begin
         coef[k] = bank[bank_sel][k];
      end
   end

   // Bank select, shadow writes and registered read-back.
   always_ff @(posedge Clk) begin
      if (!Hlt_n) begin
         bank_sel <= 1'b0;
         rd_data  <= '0;
         // NOTE: both banks are flops, not RAM, and must read as zero after
         // reset, so every entry is cleared explicitly here.
         for (int k = 0; k < N_TAPS; k++) begin
            bank[0][k] <= '0;
            bank[1][k] <= '0;
         end
      end else begin
         if (swap) begin
            bank_sel <= ~bank_sel;
         end
         // The pre-swap shadow bank is written even when it becomes active now.
         if (wr_en && wr_ok) begin
            bank[~bank_sel][wr_idx] <= wr_data;
         end
         // Read-back follows the bank that is active after this edge.
         rd_data <= rd_ok ? bank[bank_sel ^ swap][rd_idx] : '0;
      end
   end

endmodule

// File: rtl/fir_transpose_param.sv
// Parametrised transposed-form FIR with valid-qualified input, flush,
// double-buffered coefficients and round/shift/saturate output scaling.
module fir_transpose_param
   import fir_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int COEF_W    = 12,
   parameter int N_TAPS    = 16,
   parameter int ADDR_W    = 8,
   parameter int OUT_SHIFT = 0
) (
   input  logic                  Clk,
   input  logic                  Hlt_n,
   fir_transpose_param_if.slave  bus
);

   localparam int ACC_W = acc_width(DATA_W, COEF_W, N_TAPS);

   logic signed [COEF_W-1:0] coef [N_TAPS];
   logic signed [ACC_W-1:0]  part [N_TAPS-1];
   logic signed [ACC_W-1:0]  prod [N_TAPS];
   logic signed [ACC_W-1:0]  din_ext;
   logic signed [ACC_W-1:0]  acc;

   fir_coef_bank #(
      .COEF_W (COEF_W),
      .N_TAPS (N_TAPS),
      .ADDR_W (ADDR_W)
   ) u_coef (
      .Clk     (Clk),
      .Hlt_n   (Hlt_n),
      .wr_en   (bus.coef_wr_en),
      .wr_addr (bus.coef_wr_addr),
      .wr_data (bus.coef_wr_data),
      .swap    (bus.coef_swap),
      .rd_addr (bus.coef_rd_addr),
      .rd_data (bus.coef_rd_data),
      .coef    (coef)
   );

   // Tap products at full accumulator width, plus the output sum h[0]*x + p[0].
   always_comb begin
      // NOTE: every combinational output is assigned on every path so no latch
      // is inferred.
      din_ext = ACC_W'(bus.Din);
      for (int k = 0; k < N_TAPS; k++) begin
         prod[k] = din_ext * ACC_W'(coef[k]);
      end
      acc = prod[0] + part[0];
   end

   // Partial-sum chain, scaled output and one-cycle valid pulse.
   always_ff @(posedge Clk) begin
      if (!Hlt_n) begin
         // NOTE: state registers use non-blocking assignment so every flop
         // samples the pre-edge values regardless of statement order.
         for (int i = 0; i < N_TAPS - 1; i++) begin
            part[i] <= '0;
         end
         bus.Dout       <= '0;
         bus.dout_valid <= 1'b0;
      end else if (bus.flush) begin
         // Flush beats a coincident sample; Dout keeps its last value.
         for (int i = 0; i < N_TAPS - 1; i++) begin
            part[i] <= '0;
         end
         bus.dout_valid <= 1'b0;
      end else if (bus.din_valid) begin
         for (int i = 0; i < N_TAPS - 2; i++) begin
            part[i] <= prod[i+1] + part[i+1];
         end
         part[N_TAPS-2] <= prod[N_TAPS-1];
         bus.Dout       <= DATA_W'(sat_round(MAX_ACC_W'(acc), OUT_SHIFT, DATA_W));
         bus.dout_valid <= 1'b1;
      end else begin
         bus.dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_transpose_param.sv
// Directed bench for fir_transpose_param: u0 unscaled, u1 with OUT_SHIFT=1,
// both fed identical stimulus.
module tb_fir_transpose_param;

   logic Clk = 1'b0;
   logic Hlt_n = 1'b0;
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 Clk = ~Clk;

   fir_transpose_param_if #(.DATA_W(12), .COEF_W(12), .ADDR_W(8)) bus0 ();
   fir_transpose_param_if #(.DATA_W(12), .COEF_W(12), .ADDR_W(8)) bus1 ();

   fir_transpose_param #(
      .DATA_W(12), .COEF_W(12), .N_TAPS(8), .ADDR_W(8), .OUT_SHIFT(0)
   ) u0 (
      .Clk   (Clk),
      .Hlt_n (Hlt_n),
      .bus   (bus0.slave)
   );

   fir_transpose_param #(
      .DATA_W(12), .COEF_W(12), .N_TAPS(8), .ADDR_W(8), .OUT_SHIFT(1)
   ) u1 (
      .Clk   (Clk),
      .Hlt_n (Hlt_n),
      .bus   (bus1.slave)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      bus0.din_valid = 1'b0; bus0.flush = 1'b0; bus0.coef_wr_en = 1'b0; bus0.coef_swap = 1'b0;
      bus1.din_valid = 1'b0; bus1.flush = 1'b0; bus1.coef_wr_en = 1'b0; bus1.coef_swap = 1'b0;
   endtask

   // One clock; outputs are settled 1 time unit after the edge.
   task automatic cycle();
      @(posedge Clk);
      #1;
      clr();
   endtask

   task automatic sample(input bit v, input int d);
      bus0.din_valid = v; bus0.Din = 12'(d);
      bus1.din_valid = v; bus1.Din = 12'(d);
      cycle();
   endtask

   task automatic set_flush();
      bus0.flush = 1'b1;
      bus1.flush = 1'b1;
   endtask

   task automatic set_swap();
      bus0.coef_swap = 1'b1;
      bus1.coef_swap = 1'b1;
   endtask

   task automatic wr(input int addr, input int data, input bit sw);
      bus0.coef_wr_en = 1'b1; bus0.coef_wr_addr = 8'(addr); bus0.coef_wr_data = 12'(data);
      bus1.coef_wr_en = 1'b1; bus1.coef_wr_addr = 8'(addr); bus1.coef_wr_data = 12'(data);
      bus0.coef_swap = sw; bus1.coef_swap = sw;
      cycle();
   endtask

   task automatic swap();
      set_swap();
      cycle();
   endtask

   task automatic rd(input int addr);
      bus0.coef_rd_addr = 8'(addr);
      bus1.coef_rd_addr = 8'(addr);
      cycle();
   endtask

   task automatic do_reset();
      Hlt_n = 1'b0;
      cycle();
      Hlt_n = 1'b1;
   endtask

   task automatic load_ramp();
      for (int k = 0; k < 8; k++) wr(k, k + 1, 1'b0);
      swap();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int sat_exp [8];
      bus0.Din = '0; bus0.coef_wr_addr = '0; bus0.coef_wr_data = '0; bus0.coef_rd_addr = '0;
      bus1.Din = '0; bus1.coef_wr_addr = '0; bus1.coef_wr_data = '0; bus1.coef_rd_addr = '0;
      clr();

      // Reset state.
      Hlt_n = 1'b0;
      cycle();
      cycle();
      check("rst_dout", bus0.Dout, 0);
      check("rst_valid", bus0.dout_valid, 0);
      check("rst_rd", bus0.coef_rd_data, 0);
      Hlt_n = 1'b1;

      // Load h = 1..8 and read two taps back.
      load_ramp();
      rd(3);
      check("rd_h3", bus0.coef_rd_data, 4);
      rd(7);
      check("rd_h7", bus0.coef_rd_data, 8);

      // Impulse response, back-to-back samples.
      for (int n = 0; n < 9; n++) begin
         sample(1'b1, (n == 0) ? 1 : 0);
         check("imp_valid", bus0.dout_valid, 1);
         check("imp_dout", bus0.Dout, (n < 8) ? n + 1 : 0);
      end

      // Impulse with three idle cycles after each sample.
      for (int n = 0; n < 9; n++) begin
         sample(1'b1, (n == 0) ? 1 : 0);
         check("gap_valid", bus0.dout_valid, 1);
         check("gap_dout", bus0.Dout, (n < 8) ? n + 1 : 0);
         for (int g = 0; g < 3; g++) begin
            sample(1'b0, 7);
            check("gap_idle_valid", bus0.dout_valid, 0);
            check("gap_idle_hold", bus0.Dout, (n < 8) ? n + 1 : 0);
         end
      end

      // Flush mid-response; the coincident sample is dropped.
      sample(1'b1, 1); check("fl_pre0", bus0.Dout, 1);
      sample(1'b1, 0); check("fl_pre1", bus0.Dout, 2);
      sample(1'b1, 0); check("fl_pre2", bus0.Dout, 3);
      set_flush();
      sample(1'b1, 5);
      check("fl_valid", bus0.dout_valid, 0);
      check("fl_hold", bus0.Dout, 3);
      for (int n = 0; n < 5; n++) begin
         sample(1'b1, 0);
         check("fl_post", bus0.Dout, 0);
      end

      // Saturation: all h = 2047.
      for (int k = 0; k < 8; k++) wr(k, 2047, 1'b0);
      swap();
      for (int n = 0; n < 8; n++) begin
         sample(1'b1, 2047);
         check("sat_pos", bus0.Dout, 2047);
      end
      // Window with n negatives: (8-n)*2047*2047 - n*2048*2047 turns negative at n=4.
      sat_exp = '{2047, 2047, 2047, -2048, -2048, -2048, -2048, -2048};
      for (int n = 0; n < 8; n++) begin
         sample(1'b1, -2048);
         check("sat_neg", bus0.Dout, sat_exp[n]);
      end

      // Atomic swap: active h0=1, shadow h0=5.
      do_reset();
      wr(0, 1, 1'b0);
      swap();
      wr(0, 5, 1'b0);
      set_swap();
      sample(1'b1, 10);
      check("swap_old_bank", bus0.Dout, 10);
      sample(1'b1, 10);
      check("swap_new_bank", bus0.Dout, 50);
      rd(0);
      check("swap_rd0", bus0.coef_rd_data, 5);
      wr(9, 7, 1'b0);
      swap();
      rd(1);
      check("oor_wr_alias", bus0.coef_rd_data, 0);
      rd(9);
      check("oor_rd", bus0.coef_rd_data, 0);
      wr(2, 3, 1'b1);
      rd(2);
      check("wr_swap_same", bus0.coef_rd_data, 3);

      // Rounding: h0=1 only; u1 shifts by one with round half up.
      do_reset();
      wr(0, 1, 1'b0);
      swap();
      sample(1'b1, 3);
      check("rnd_u0_p3", bus0.Dout, 3);
      check("rnd_u1_p3", bus1.Dout, 2);
      sample(1'b1, -3);
      check("rnd_u0_m3", bus0.Dout, -3);
      check("rnd_u1_m3", bus1.Dout, -1);

      // Reset mid-stream.
      do_reset();
      load_ramp();
      sample(1'b1, 1); check("mr_pre0", bus0.Dout, 1);
      sample(1'b1, 0); check("mr_pre1", bus0.Dout, 2);
      Hlt_n = 1'b0;
      sample(1'b1, 1);
      Hlt_n = 1'b1;
      check("mr_dout", bus0.Dout, 0);
      check("mr_valid", bus0.dout_valid, 0);
      rd(0);
      check("mr_coef0", bus0.coef_rd_data, 0);
      rd(5);
      check("mr_coef5", bus0.coef_rd_data, 0);
      for (int n = 0; n < 8; n++) begin
         sample(1'b1, (n == 0) ? 1 : 0);
         check("mr_imp_valid", bus0.dout_valid, 1);
         check("mr_imp_dout", bus0.Dout, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
